// File: rtl/decode_ibuf_if.sv
// Fetch/decode handshake, operand and redirect bundle for decode_ibuf.
// master = surrounding pipeline (fetch, register file, bypass network); slave = decode_ibuf.
interface decode_ibuf_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int NBYP  = 3
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [31:0]          in_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_instr;
  logic [XLEN-1:0]      out_imm;
  logic [4:0]           out_ra1;
  logic [4:0]           out_ra2;
  logic [4:0]           out_dst;
  logic [XLEN-1:0]      rd1;
  logic [XLEN-1:0]      rd2;
  logic [NBYP-1:0]      byp_valid;
  logic [5*NBYP-1:0]    byp_dst;
  logic [XLEN*NBYP-1:0] byp_data;
  logic [XLEN-1:0]      out_srca;
  logic [XLEN-1:0]      out_srcb;
  logic                 redirect;
  logic [XLEN-1:0]      redirect_pc;
  logic                 flush;
  logic [CW-1:0]        count;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, rd1, rd2,
           byp_valid, byp_dst, byp_data, flush,
    input  in_ready, out_valid, out_pc, out_instr, out_imm, out_ra1, out_ra2,
           out_dst, out_srca, out_srcb, redirect, redirect_pc, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, rd1, rd2,
           byp_valid, byp_dst, byp_data, flush,
    output in_ready, out_valid, out_pc, out_instr, out_imm, out_ra1, out_ra2,
           out_dst, out_srca, out_srcb, redirect, redirect_pc, count
  );
endinterface

// File: rtl/decode_ibuf.sv
// Decode front end: instruction FIFO, RV64I immediate, operand forwarding, branch/jump resolution.
// Optional zero-latency empty-buffer bypass: define DECODE_IBUF_PASSTHRU_EN.
module decode_ibuf #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int NBYP  = 3
) (
  input  logic         clk,
  input  logic         reset,
  decode_ibuf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_instr [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            r_redirect;
  logic [XLEN-1:0] r_redirect_pc;

  logic            w_pt;
  logic            w_out_valid;
  logic            w_in_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_pop_mem;
  logic            w_taken;
  logic [XLEN-1:0] w_head_pc;
  logic [31:0]     w_head_instr;
  logic [6:0]      w_opc;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_srcb;
  logic [XLEN-1:0] w_jalr_sum;
  logic            w_br_taken;
  logic [XLEN-1:0] w_target;
  logic [NBYP-1:0]      w_byp_valid;
  logic [5*NBYP-1:0]    w_byp_dst;
  logic [XLEN*NBYP-1:0] w_byp_data;

`ifdef DECODE_IBUF_PASSTHRU_EN
  assign w_pt = (r_count == {CW{1'b0}}) & bus.in_valid & ~r_redirect & ~bus.flush;
`else
  assign w_pt = 1'b0;
`endif

  assign w_head_pc    = w_pt ? bus.in_pc    : r_pc[r_rd];
  assign w_head_instr = w_pt ? bus.in_instr : r_instr[r_rd];
  assign w_out_valid  = (r_count != {CW{1'b0}}) | w_pt;
  assign w_in_ready   = (r_count != FULL);
  assign w_pop        = w_out_valid & bus.out_ready;
  assign w_pop_mem    = w_pop & ~w_pt;
  // A bypassed-and-consumed instruction never occupies a slot.
  assign w_push       = bus.in_valid & w_in_ready & ~r_redirect & ~bus.flush
                        & ~(w_pt & bus.out_ready);
  assign w_taken      = w_pop & w_br_taken;

  assign w_opc   = w_head_instr[6:0];
  assign w_imm_i = {{(XLEN-12){w_head_instr[31]}}, w_head_instr[31:20]};
  assign w_imm_s = {{(XLEN-12){w_head_instr[31]}}, w_head_instr[31:25], w_head_instr[11:7]};
  assign w_imm_b = {{(XLEN-13){w_head_instr[31]}}, w_head_instr[31], w_head_instr[7],
                    w_head_instr[30:25], w_head_instr[11:8], 1'b0};
  assign w_imm_u = {{(XLEN-32){w_head_instr[31]}}, w_head_instr[31:12], 12'h000};
  assign w_imm_j = {{(XLEN-21){w_head_instr[31]}}, w_head_instr[31], w_head_instr[19:12],
                    w_head_instr[20], w_head_instr[30:21], 1'b0};

  assign w_byp_valid = bus.byp_valid;
  assign w_byp_dst   = bus.byp_dst;
  assign w_byp_data  = bus.byp_data;

  // Youngest matching bypass wins; scanning oldest-first lets lower indices override.
  function automatic logic [XLEN-1:0] fwd(input logic [4:0] ra, input logic [XLEN-1:0] rdv);
    logic [XLEN-1:0] v;
    v = rdv;
    for (int i = NBYP - 1; i >= 0; i--) begin
      if ((ra != 5'd0) && w_byp_valid[i] && (w_byp_dst[i*5 +: 5] == ra)) begin
        v = w_byp_data[i*XLEN +: XLEN];
      end else begin
        v = v;
      end
    end
    return v;
  endfunction

  assign w_srca     = fwd(w_head_instr[19:15], bus.rd1);
  assign w_srcb     = fwd(w_head_instr[24:20], bus.rd2);
  assign w_jalr_sum = w_srca + w_imm_i;

  // Head immediate selection by opcode.
  always_comb begin
    w_imm = {XLEN{1'b0}};
    case (w_opc)
      OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: w_imm = w_imm_i;
      OP_STORE:                           w_imm = w_imm_s;
      OP_BRANCH:                          w_imm = w_imm_b;
      OP_LUI:                             w_imm = w_imm_u;
      OP_AUIPC:                           w_imm = w_imm_u + w_head_pc;
      OP_JAL:                             w_imm = w_head_pc + XLEN'(4);
      default:                            w_imm = {XLEN{1'b0}};
    endcase
  end

  // Branch/jump decision and target for the head entry.
  always_comb begin
    w_br_taken = 1'b0;
    w_target   = w_head_pc + w_imm_b;
    case (w_opc)
      OP_BRANCH: begin
        case (w_head_instr[14:12])
          3'b000:  w_br_taken = (w_srca == w_srcb);
          3'b001:  w_br_taken = (w_srca != w_srcb);
          3'b100:  w_br_taken = ($signed(w_srca) <  $signed(w_srcb));
          3'b101:  w_br_taken = ($signed(w_srca) >= $signed(w_srcb));
          3'b110:  w_br_taken = (w_srca <  w_srcb);
          3'b111:  w_br_taken = (w_srca >= w_srcb);
          default: w_br_taken = 1'b0;
        endcase
      end
      OP_JAL: begin
        w_br_taken = 1'b1;
        w_target   = w_head_pc + w_imm_j;
      end
      OP_JALR: begin
        w_br_taken = 1'b1;
        w_target   = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      default: begin
        w_br_taken = 1'b0;
        w_target   = w_head_pc + w_imm_b;
      end
    endcase
  end

  // FIFO pointers/occupancy, storage and registered redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr          <= {AW{1'b0}};
      r_rd          <= {AW{1'b0}};
      r_count       <= {CW{1'b0}};
      r_redirect    <= 1'b0;
      r_redirect_pc <= {XLEN{1'b0}};
    end else if (bus.flush) begin
      r_count    <= {CW{1'b0}};
      r_rd       <= r_wr;
      r_redirect <= 1'b0;
    end else if (w_taken) begin
      r_redirect    <= 1'b1;
      r_redirect_pc <= w_target;
      r_count       <= {CW{1'b0}};
      r_rd          <= r_wr;
    end else begin
      r_redirect <= 1'b0;
      if (w_push) begin
        r_pc[r_wr]    <= bus.in_pc;
        r_instr[r_wr] <= bus.in_instr;
        r_wr          <= r_wr + AW'(1);
      end
      if (w_pop_mem) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push, w_pop_mem})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_pc      = w_head_pc;
  assign bus.out_instr   = w_head_instr;
  assign bus.out_imm     = w_imm;
  assign bus.out_ra1     = w_head_instr[19:15];
  assign bus.out_ra2     = w_head_instr[24:20];
  assign bus.out_dst     = w_head_instr[11:7];
  assign bus.out_srca    = w_srca;
  assign bus.out_srcb    = w_srcb;
  assign bus.redirect    = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;
  assign bus.count       = r_count;
endmodule

// File: tb/tb_decode_ibuf.sv
// Directed self-checking bench for decode_ibuf (default build, DEPTH=4, XLEN=64, NBYP=3).
module tb_decode_ibuf;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_ADD  = 32'h002081B3; // add x3,x1,x2
  localparam logic [31:0] I_ADD0 = 32'h002001B3; // add x3,x0,x2
  localparam logic [31:0] I_BLT  = 32'h0220C063; // blt x1,x2,+0x20
  localparam logic [31:0] I_BLTU = 32'h0220E063; // bltu x1,x2,+0x20
  localparam logic [31:0] I_JALR = 32'h00408067; // jalr x0,4(x1)
  localparam logic [31:0] I_JAL  = 32'h008000EF; // jal x1,+8
  localparam logic [31:0] I_LUI  = 32'h800002B7; // lui x5,0x80000

  decode_ibuf_if #(.DEPTH(4), .XLEN(64), .NBYP(3)) bus ();

  decode_ibuf #(.DEPTH(4), .XLEN(64), .NBYP(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc, input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_instr = instr;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = 64'd0;
    bus.in_instr  = 32'd0;
    bus.out_ready = 1'b0;
    bus.rd1       = 64'd0;
    bus.rd2       = 64'd0;
    bus.byp_valid = 3'b000;
    bus.byp_dst   = 15'd0;
    bus.byp_data  = 192'd0;
    bus.flush     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_redirect", 64'(bus.redirect), 64'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 64'd0);

    // Fill to DEPTH, then one held push, then drain in order.
    for (int k = 0; k < 4; k++) begin
      push(64'(k * 4), I_NOP);
      if (k == 0) chk("fill_latency_valid", 64'(bus.out_valid), 64'd1);
    end
    chk("fill_count", 64'(bus.count), 64'd4);
    chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
    push(64'h10, I_NOP);
    chk("fill_held_count", 64'(bus.count), 64'd4);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_pc%0d", k), bus.out_pc, 64'(k * 4));
      tick();
    end
    chk("drain_count", 64'(bus.count), 64'd0);
    chk("drain_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b0;

    // Forwarding priority and x0 handling.
    push(64'h40, I_ADD);
    bus.rd1 = 64'd111;
    bus.rd2 = 64'd222;
    bus.byp_valid = 3'b111;
    bus.byp_dst   = {5'd1, 5'd1, 5'd1};
    bus.byp_data  = {64'd30, 64'd20, 64'd10};
    #1;
    chk("fwd_ra1", 64'(bus.out_ra1), 64'd1);
    chk("fwd_ra2", 64'(bus.out_ra2), 64'd2);
    chk("fwd_dst", 64'(bus.out_dst), 64'd3);
    chk("fwd_srca_idx0", bus.out_srca, 64'd10);
    chk("fwd_srcb_rf", bus.out_srcb, 64'd222);
    chk("fwd_imm_rtype", bus.out_imm, 64'd0);
    bus.byp_valid = 3'b110;
    #1;
    chk("fwd_srca_idx1", bus.out_srca, 64'd20);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    push(64'h44, I_ADD0);
    bus.byp_valid = 3'b111;
    bus.byp_dst   = {5'd0, 5'd0, 5'd0};
    #1;
    chk("fwd_x0_srca", bus.out_srca, 64'd111);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.byp_valid = 3'b000;

    // BLT taken with a same-cycle push, then a push ignored while redirecting.
    push(64'h100, I_BLT);
    bus.rd1 = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.rd2 = 64'd1;
    #1;
    chk("blt_imm", bus.out_imm, 64'h20);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h104;
    bus.in_instr  = I_NOP;
    tick();
    chk("blt_redirect", 64'(bus.redirect), 64'd1);
    chk("blt_redirect_pc", bus.redirect_pc, 64'h120);
    chk("blt_count", 64'(bus.count), 64'd0);
    tick();
    chk("blt_redirect_pulse", 64'(bus.redirect), 64'd0);
    chk("blt_push_ignored", 64'(bus.count), 64'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // BLTU with the same operands is not taken.
    push(64'h100, I_BLTU);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bltu_redirect", 64'(bus.redirect), 64'd0);
    chk("bltu_count", 64'(bus.count), 64'd0);

    // JALR target clears bit 0.
    push(64'h200, I_JALR);
    bus.rd1 = 64'h1003;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("jalr_redirect", 64'(bus.redirect), 64'd1);
    chk("jalr_redirect_pc", bus.redirect_pc, 64'h1006);

    // JAL link value and target, then async reset while redirect is high.
    tick();
    push(64'h80, I_JAL);
    chk("jal_imm_link", bus.out_imm, 64'h84);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("jal_redirect_pc", bus.redirect_pc, 64'h88);
    reset = 1'b1;
    #1;
    chk("async_rst_redirect", 64'(bus.redirect), 64'd0);
    chk("async_rst_redirect_pc", bus.redirect_pc, 64'd0);
    tick();
    reset = 1'b0;

    // LUI immediate is sign-extended; clear it with a plain flush.
    push(64'h300, I_LUI);
    chk("lui_imm", bus.out_imm, 64'hFFFF_FFFF_8000_0000);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_count", 64'(bus.count), 64'd0);

    // Flush beats a same-cycle push and a taken branch pop.
    push(64'h100, I_BLT);
    push(64'h104, I_NOP);
    chk("flushmix_count_pre", 64'(bus.count), 64'd2);
    bus.rd1 = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.rd2 = 64'd1;
    bus.flush     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pc     = 64'h108;
    bus.in_instr  = I_NOP;
    bus.out_ready = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("flushmix_count", 64'(bus.count), 64'd0);
    chk("flushmix_redirect", 64'(bus.redirect), 64'd0);
    chk("flushmix_out_valid", 64'(bus.out_valid), 64'd0);

    // Async reset mid-drain, then a normal push after release.
    push(64'h500, I_NOP);
    push(64'h504, I_NOP);
    push(64'h508, I_NOP);
    bus.out_ready = 1'b1;
    tick();
    chk("middrain_count_pre", 64'(bus.count), 64'd2);
    #3;
    reset = 1'b1;
    #1;
    chk("middrain_out_valid", 64'(bus.out_valid), 64'd0);
    chk("middrain_count", 64'(bus.count), 64'd0);
    chk("middrain_redirect", 64'(bus.redirect), 64'd0);
    bus.out_ready = 1'b0;
    tick();
    reset = 1'b0;
    push(64'h600, I_NOP);
    chk("post_rst_count", 64'(bus.count), 64'd1);
    chk("post_rst_pc", bus.out_pc, 64'h600);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
